// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: shared FSM state type and address/parameter constants.
package dmem_responder_pkg;
    typedef enum logic [1:0] {IDLE, WAITING, RESP} state_t;
    localparam logic [31:0] PERF_ADDR     = 32'h0000_0FFC;
    localparam int          DEFAULT_DEPTH = 64;
    localparam int          DEFAULT_WAIT  = 2;
endpackage

// File: rtl/dmem_responder_ram.sv
// dmem_responder_ram: DEPTH x 32 data array, one write port, asynchronous read.
module dmem_responder_ram
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);
    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge clk)
        if (i_we) r_mem[i_addr] <= i_wdata;

    assign o_rdata = r_mem[i_addr];
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: wait-state data memory responder (IDLE/WAITING/RESP FSM).
// Define DMEM_RESPONDER_PERF_EN to add the PERF_ADDR access counter.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int WAIT  = DEFAULT_WAIT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        ready,
    output logic        err
);
    localparam int AW = $clog2(DEPTH);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [31:0] r_a;
    logic [31:0] r_wd;
    logic [31:0] w_rdata;
    logic [31:0] w_perf_val;
    logic        w_resp;
    logic        w_perf;
    logic        w_bad;
    logic        w_err;
    logic        w_wr;

    assign w_resp = r_state == RESP;
    assign w_bad  = (r_a[1:0] != 2'b00) || (r_a[31:2] >= 30'(DEPTH));
    assign w_err  = !w_perf && w_bad;
    assign w_wr   = w_resp && r_we && !w_err && !w_perf;
    assign ready  = w_resp;
    assign err    = w_resp && w_err;
    assign rd     = (w_resp && !r_we && !w_err) ? (w_perf ? w_perf_val : w_rdata) : 32'h0;

    dmem_responder_ram #(.DEPTH(DEPTH)) u_ram (
        .clk    (clk),
        .i_we   (w_wr),
        .i_addr (r_a[AW+1:2]),
        .i_wdata(r_wd),
        .o_rdata(w_rdata)
    );

    // WAITING leaves when the count expires so the RESP cycle lands WAIT+1 edges after accept
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else begin
            case (r_state)
                IDLE: if (req) begin
                    r_a     <= a;
                    r_we    <= we;
                    r_wd    <= wd;
                    r_cnt   <= 4'(WAIT);
                    r_state <= (WAIT == 0) ? RESP : WAITING;
                end
                WAITING: begin
                    r_cnt   <= r_cnt - 4'd1;
                    r_state <= (r_cnt <= 4'd1) ? RESP : WAITING;
                end
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef DMEM_RESPONDER_PERF_EN
    logic [31:0] r_perf;

    assign w_perf     = r_a == PERF_ADDR;
    assign w_perf_val = r_perf;

    // A clearing store is itself a good access, so the count restarts at 1
    always_ff @(posedge clk) begin
        if (reset)
            r_perf <= 32'h0;
        else if (w_resp && !w_err)
            r_perf <= (w_perf && r_we) ? 32'h1 : r_perf + 32'h1;
    end
`else
    assign w_perf     = 1'b0;
    assign w_perf_val = 32'h0;
`endif
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed table, corner sequences and random accesses vs a reference model.
module tb_dmem_responder;
    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset, req, we, ready, err;
    logic [31:0] a, wd, rd;
    logic        req1, we1, ready1, err1;
    logic [31:0] a1, wd1, rd1;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem [DEPTH];
    logic [31:0] pcnt;

    typedef struct {
        logic        w;
        logic [31:0] ad;
        logic [31:0] d;
        logic [31:0] erd;
        logic        eerr;
    } vec_t;
    vec_t tbl [8];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(DEPTH), .WAIT(2)) u0 (
        .clk(clk), .reset(reset), .req(req), .we(we), .a(a), .wd(wd),
        .rd(rd), .ready(ready), .err(err)
    );

    dmem_responder #(.DEPTH(DEPTH), .WAIT(0)) u1 (
        .clk(clk), .reset(reset), .req(req1), .we(we1), .a(a1), .wd(wd1),
        .rd(rd1), .ready(ready1), .err(err1)
    );

    function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endfunction

    function automatic void model(input logic w, input logic [31:0] ad, input logic [31:0] d,
                                  output logic [31:0] erd, output logic eerr);
        bit perf;
`ifdef DMEM_RESPONDER_PERF_EN
        perf = (ad == 32'hFFC);
`else
        perf = 1'b0;
`endif
        erd  = 32'h0;
        eerr = 1'b0;
        if (perf) begin
            erd  = w ? 32'h0 : pcnt;
            pcnt = w ? 32'h1 : pcnt + 1;
        end else if (ad % 4 != 0 || ad / 4 >= DEPTH) begin
            eerr = 1'b1;
        end else begin
            if (w) mem[ad/4] = d;
            else   erd = mem[ad/4];
            pcnt = pcnt + 1;
        end
    endfunction

    // Starts and ends on a negedge with u0 idle; scrambles inputs after acceptance.
    task automatic access(input logic w, input logic [31:0] ad, input logic [31:0] d,
                          output logic [31:0] grd, output logic gerr);
        int  lat = 0;
        bit  seen = 0;
        req = 1'b1; we = w; a = ad; wd = d;
        @(posedge clk);
        #1;
        req = 1'($urandom_range(0, 1)); we = 1'($urandom); a = $urandom; wd = $urandom;
        grd = 'x; gerr = 1'bx;
        while (!seen && lat < 20) begin
            @(negedge clk);
            lat++;
            if (ready) begin
                seen = 1;
                grd  = rd;
                gerr = err;
                req  = 1'b0;
                check("latency", 32'(lat), 32'd3);
            end else begin
                check("idle_outputs", rd | {31'b0, err}, 32'h0);
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL timeout: no ready within 20 cycles for a=%h", ad);
            req = 1'b0;
        end
        @(negedge clk);
        check("ready_one_cycle", {31'b0, ready}, 32'h0);
    endtask

    task automatic acc_model(input logic w, input logic [31:0] ad, input logic [31:0] d);
        logic [31:0] grd, erd;
        logic        gerr, eerr;
        access(w, ad, d, grd, gerr);
        model(w, ad, d, erd, eerr);
        check("model_rd", grd, erd);
        check("model_err", {31'b0, gerr}, {31'b0, eerr});
    endtask

    task automatic dir(input string n, input logic w, input logic [31:0] ad, input logic [31:0] d,
                       input logic [31:0] erd, input logic eerr);
        logic [31:0] grd, mrd;
        logic        gerr, merr;
        access(w, ad, d, grd, gerr);
        model(w, ad, d, mrd, merr);
        check({n, "_rd"}, grd, erd);
        check({n, "_err"}, {31'b0, gerr}, {31'b0, eerr});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        pcnt = 32'h0;
        @(negedge clk);
    endtask

    initial begin
        int          pulses;
        int          r;
        logic [31:0] ad;
        reset = 1'b1; req = 0; we = 0; a = 0; wd = 0;
        req1 = 0; we1 = 0; a1 = 0; wd1 = 0;
        pcnt = 32'h0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_ready", {31'b0, ready}, 32'h0);
        check("reset_err", {31'b0, err}, 32'h0);
        check("reset_rd", rd, 32'h0);

        for (int i = 0; i < DEPTH; i++) acc_model(1'b1, 32'(i * 4), 32'h1000 + 32'(i));

        tbl[0] = '{1'b1, 32'h64, 32'h7,        32'h0,        1'b0};
        tbl[1] = '{1'b0, 32'h64, 32'h0,        32'h7,        1'b0};
        tbl[2] = '{1'b1, 32'h66, 32'h55,       32'h0,        1'b1};
        tbl[3] = '{1'b1, 32'h100, 32'h66,      32'h0,        1'b1};
        tbl[4] = '{1'b0, 32'h64, 32'h0,        32'h7,        1'b0};
        tbl[5] = '{1'b1, 32'hFC, 32'hDEADBEEF, 32'h0,        1'b0};
        tbl[6] = '{1'b0, 32'hFC, 32'h0,        32'hDEADBEEF, 1'b0};
        tbl[7] = '{1'b0, 32'h3,  32'h0,        32'h0,        1'b1};
        for (int i = 0; i < 8; i++)
            dir($sformatf("tbl%0d", i), tbl[i].w, tbl[i].ad, tbl[i].d, tbl[i].erd, tbl[i].eerr);

        req = 1'b1; we = 1'b1; a = 32'h60; wd = 32'h5;
        @(posedge clk);
        #1 req = 1'b0; reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        pcnt   = 32'h0;
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (ready) pulses++;
        end
        check("abort_no_ready", 32'(pulses), 32'h0);
        dir("abort_old", 1'b0, 32'h60, 32'h0, 32'h1018, 1'b0);

`ifdef DMEM_RESPONDER_PERF_EN
        do_reset();
        for (int i = 0; i < 3; i++) acc_model(1'b0, 32'(i * 4), 32'h0);
        dir("perf_load3", 1'b0, 32'hFFC, 32'h0, 32'h3, 1'b0);
        dir("perf_clear", 1'b1, 32'hFFC, 32'h0, 32'h0, 1'b0);
        dir("perf_load1", 1'b0, 32'hFFC, 32'h0, 32'h1, 1'b0);
`else
        dir("noperf_ffc", 1'b0, 32'hFFC, 32'h0, 32'h0, 1'b1);
`endif

        for (int i = 0; i < 300; i++) begin
            r  = int'($urandom_range(0, 9));
            ad = r < 7  ? $urandom_range(0, DEPTH - 1) * 4 :
                 r == 7 ? $urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3) :
                 r == 8 ? 32'h100 + $urandom_range(0, 1000) * 4 : 32'hFFC;
            acc_model(1'($urandom), ad, $urandom);
        end

        req1 = 1'b1; we1 = 1'b1; a1 = 32'h0; wd1 = 32'hA0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            a1  = 32'((k + 1) * 4);
            wd1 = 32'hA0 + 32'(k + 1);
            if (k == 3) req1 = 1'b0;
            @(negedge clk);
            check("w0_ready", {31'b0, ready1}, 32'h1);
            check("w0_err", {31'b0, err1}, 32'h0);
            @(negedge clk);
            check("w0_gap", {31'b0, ready1}, 32'h0);
        end
        for (int k = 0; k < 4; k++) begin
            req1 = 1'b1; we1 = 1'b0; a1 = 32'(k * 4);
            @(posedge clk);
            #1 req1 = 1'b0;
            @(negedge clk);
            check("w0_rd_ready", {31'b0, ready1}, 32'h1);
            check("w0_rd", rd1, 32'hA0 + 32'(k));
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
